// File: rtl/alu_ex_latch_pkg.sv
// Shared ALU opcode/status constants and skid-buffer state encoding for the EX->WB stage.
package alu_ex_latch_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;

    localparam int unsigned ST_ADD_OVF = 1;
    localparam int unsigned ST_SUB_OVF = 3;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Overflow is only architecturally meaningful for add/sub.
    function automatic logic ovf_applies(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB);
    endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Generic 2-entry valid/ready skid register (main + skid) with synchronous flush.
module ex_skid_buf
    import alu_ex_latch_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q;
    skid_state_e  state_d;
    logic [W-1:0] skid_q;
    logic         accept_c;
    logic         main_from_in_c;
    logic         main_from_skid_c;
    logic         skid_load_c;
    logic         main_clear_c;

    assign accept_c = in_valid & in_ready;

    // Occupancy FSM: at most one entry moves into main per cycle, skid drains first.
    always_comb begin
        state_d          = state_q;
        main_from_in_c   = 1'b0;
        main_from_skid_c = 1'b0;
        skid_load_c      = 1'b0;
        main_clear_c     = 1'b0;
        if (flush) begin
            state_d      = SKID_EMPTY;
            main_clear_c = 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept_c) begin
                        main_from_in_c = 1'b1;
                        state_d        = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (out_ready) begin
                        if (accept_c) begin
                            main_from_in_c = 1'b1;
                        end else begin
                            main_clear_c = 1'b1;
                            state_d      = SKID_EMPTY;
                        end
                    end else if (accept_c) begin
                        skid_load_c = 1'b1;
                        state_d     = SKID_TWO;
                    end
                end
                SKID_TWO: begin
                    if (out_ready) begin
                        main_from_skid_c = 1'b1;
                        state_d          = SKID_ONE;
                    end
                end
                default: begin
                    state_d      = SKID_EMPTY;
                    main_clear_c = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d != SKID_EMPTY);
            in_ready  <= (state_d != SKID_TWO);
        end
    end

    // Main payload is zeroed when the stage empties so stale write enables never leak.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            skid_q   <= '0;
        end else begin
            if (main_clear_c) begin
                out_data <= '0;
            end else if (main_from_skid_c) begin
                out_data <= skid_q;
            end else if (main_from_in_c) begin
                out_data <= in_data;
            end
            if (skid_load_c) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_ex_latch.sv
// EX->WB pipeline stage: overflow rewrite to the status register, overflow counter, 2-deep skid.
module alu_ex_latch
    import alu_ex_latch_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned RD_W       = 4,
    parameter int unsigned STATUS_REG = 15,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_ne,
    input  logic             in_lt,
    input  logic             in_ovf,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_we,
    output logic             out_ne,
    output logic             out_lt,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned PAY_W = WIDTH + RD_W + 3;

    logic             rewrite_c;
    logic [WIDTH-1:0] cap_data_c;
    logic [RD_W-1:0]  cap_rd_c;
    logic             cap_we_c;
    logic [PAY_W-1:0] pay_in_c;
    logic [PAY_W-1:0] pay_out;

    // Overflow rewrite at capture; flags pass through untouched.
    always_comb begin
        rewrite_c  = in_ovf & ovf_applies(in_opcode);
        cap_data_c = in_result;
        cap_rd_c   = in_rd;
        cap_we_c   = in_we;
        if (rewrite_c) begin
            cap_data_c = (in_opcode == OP_SUB) ? WIDTH'(ST_SUB_OVF) : WIDTH'(ST_ADD_OVF);
            cap_rd_c   = RD_W'(STATUS_REG);
            cap_we_c   = 1'b1;
        end
        pay_in_c = {cap_we_c, in_ne, in_lt, cap_rd_c, cap_data_c};
    end

    ex_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign {out_we, out_ne, out_lt, out_rd, out_data} = pay_out;

    // Saturating count of accepted rewrites; flush-dropped inputs never count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count <= '0;
        end else if (in_valid && in_ready && !flush && rewrite_c && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ex_latch.sv
// Directed self-checking bench for alu_ex_latch with hand-computed expectations.
module tb_alu_ex_latch;
    import alu_ex_latch_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_ne;
    logic        in_lt;
    logic        in_ovf;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        out_ne;
    logic        out_lt;
    logic [7:0]  ovf_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_ex_latch #(
        .WIDTH (16), .RD_W (4), .STATUS_REG (15), .CNT_W (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_ne     (in_ne),
        .in_lt     (in_lt),
        .in_ovf    (in_ovf),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_ne    (out_ne),
        .out_lt    (out_lt),
        .ovf_count (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [4:0] op,
                         input logic ovf, input logic [3:0] rd);
        in_valid  = v;
        in_result = res;
        in_opcode = op;
        in_ovf    = ovf;
        in_rd     = rd;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_ne = 1'b0; in_lt = 1'b0; in_we = 1'b1;
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_rd",    32'(out_rd),    32'd0);
        check("rst_out_we",    32'(out_we),    32'd0);
        check("rst_flags",     32'({out_ne, out_lt}), 32'd0);
        check("rst_count",     32'(ovf_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Streaming, one-cycle latency, no backpressure
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i), OP_AND, 1'b0, 4'd2);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data",  32'(out_data),  32'(i));
            check("stream_ready", 32'(in_ready),  32'd1);
        end
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        tick();
        check("stream_drain", 32'(out_valid), 32'd0);
        check("drain_we_low", 32'(out_we),    32'd0);

        // Backpressure: A to main, B to skid, C refused
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, OP_OR, 1'b0, 4'd1);
        tick();
        check("bp_a_data",  32'(out_data), 32'h00AA);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h00BB, OP_OR, 1'b0, 4'd1);
        tick();
        check("bp_b_hold",  32'(out_data), 32'h00AA);
        check("bp_b_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h00CC, OP_OR, 1'b0, 4'd1);
        tick();
        check("bp_c_hold",  32'(out_data), 32'h00AA);
        check("bp_c_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_b_out",   32'(out_data), 32'h00BB);
        check("bp_b_rdy1",  32'(in_ready), 32'd1);
        tick();
        check("bp_c_out",   32'(out_data), 32'h00CC);
        check("bp_c_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Overflow rewrite
        drive(1'b1, 16'h8000, OP_ADD, 1'b1, 4'd3);
        tick();
        check("ovf_add_rd",   32'(out_rd),    32'd15);
        check("ovf_add_data", 32'(out_data),  32'd1);
        check("ovf_add_we",   32'(out_we),    32'd1);
        check("ovf_add_cnt",  32'(ovf_count), 32'd1);
        in_ne = 1'b1;
        drive(1'b1, 16'h8000, OP_SUB, 1'b1, 4'd3);
        tick();
        check("ovf_sub_data", 32'(out_data),  32'd3);
        check("ovf_sub_rd",   32'(out_rd),    32'd15);
        check("ovf_sub_ne",   32'({out_ne, out_lt}), 32'd2);
        check("ovf_sub_cnt",  32'(ovf_count), 32'd2);
        in_ne = 1'b0; in_lt = 1'b1;
        drive(1'b1, 16'h8000, OP_AND, 1'b1, 4'd3);
        tick();
        check("ovf_and_data", 32'(out_data),  32'h8000);
        check("ovf_and_rd",   32'(out_rd),    32'd3);
        check("ovf_and_lt",   32'({out_ne, out_lt}), 32'd1);
        check("ovf_and_cnt",  32'(ovf_count), 32'd2);
        in_lt = 1'b0;
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        tick();

        // Flush with both entries held and an input offered
        out_ready = 1'b0;
        drive(1'b1, 16'h0011, OP_OR, 1'b0, 4'd4);
        tick();
        drive(1'b1, 16'h0022, OP_OR, 1'b0, 4'd4);
        tick();
        check("fl_full_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 16'h8000, OP_ADD, 1'b1, 4'd4);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        check("fl_full_valid", 32'(out_valid), 32'd0);
        check("fl_full_ready1", 32'(in_ready), 32'd1);
        check("fl_full_cnt",   32'(ovf_count), 32'd2);
        // Flush with main only: the overflow input is accept-eligible but must be dropped
        drive(1'b1, 16'h0033, OP_OR, 1'b0, 4'd4);
        tick();
        flush = 1'b1;
        drive(1'b1, 16'h8000, OP_ADD, 1'b1, 4'd4);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        check("fl_one_valid", 32'(out_valid), 32'd0);
        check("fl_one_cnt",   32'(ovf_count), 32'd2);
        tick();
        check("fl_stays_empty", 32'(out_valid), 32'd0);

        // Saturation: 300 overflow adds
        out_ready = 1'b1;
        drive(1'b1, 16'h7FFF, OP_ADD, 1'b1, 4'd5);
        for (int i = 0; i < 253; i++) tick();
        check("sat_reach", 32'(ovf_count), 32'd255);
        for (int i = 0; i < 47; i++) tick();
        check("sat_hold",  32'(ovf_count), 32'd255);

        // Async reset mid-stream with entries held
        out_ready = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready),  32'd1);
        check("arst_cnt",   32'(ovf_count), 32'd0);
        drive(1'b0, 16'h0, OP_AND, 1'b0, 4'd0);
        #3;
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
